// File: rtl/freq_sweep_pkg.sv
// Shared types and constants for the frequency-sweep sequencer.
package freq_sweep_pkg;

    typedef enum logic {ST_IDLE, ST_RUN} sweep_state_t;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_SAW    = 2'b01;
    localparam logic [1:0] MODE_TRI    = 2'b10;

    localparam logic [31:0] STEP_MIN     = 32'd26;
    localparam logic [31:0] STEP_MAX     = 32'd1301505241;
    localparam logic [31:0] DEFAULT_STEP = 32'd26030;

    // Carry bit of the next-point sum/difference marks overflow/borrow.
    typedef logic [32:0] sum33_t;

    function automatic logic [31:0] clamp_step(input logic [31:0] v);
        if (v < STEP_MIN) return STEP_MIN;
        if (v > STEP_MAX) return STEP_MAX;
        return v;
    endfunction

endpackage

// File: rtl/freq_sweep_ctrl_if.sv
// Config/control inputs and DDS-facing outputs of the sweep sequencer.
interface freq_sweep_ctrl_if #(parameter int DWELL_W = 32);
    logic [31:0]        cfg_start_step;
    logic [31:0]        cfg_stop_step;
    logic [31:0]        cfg_incr;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [1:0]         cfg_mode;
    logic               start;
    logic               abort;
    logic               phase_en;
    logic [31:0]        set_phase_step;
    logic               busy;
    logic               done;

    modport master (
        output cfg_start_step, cfg_stop_step, cfg_incr, cfg_dwell, cfg_mode, start, abort,
        input  phase_en, set_phase_step, busy, done
    );

    modport slave (
        input  cfg_start_step, cfg_stop_step, cfg_incr, cfg_dwell, cfg_mode, start, abort,
        output phase_en, set_phase_step, busy, done
    );
endinterface

// File: rtl/sweep_dwell_timer.sv
// Loadable down-counter; expire is high while enabled and the count sits at zero.
module sweep_dwell_timer #(
    parameter int DWELL_W = 32
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               en,
    output logic               expire
);
    logic [DWELL_W-1:0] cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - DWELL_W'(1);
    end

    assign expire = en && (cnt == '0);
endmodule

// File: rtl/freq_sweep_ctrl.sv
// Frequency-sweep sequencer: steps a phase-increment word lo->hi with a
// per-point dwell, in single, sawtooth or triangle mode.
module freq_sweep_ctrl
    import freq_sweep_pkg::*;
#(
    parameter int DWELL_W = 32
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    freq_sweep_ctrl_if.slave sw
);
    sweep_state_t       state;
    logic [31:0]        lo_q, hi_q, incr_q, cur_q;
    logic [DWELL_W-1:0] dwell_m1_q;
    logic               single_q, tri_q, down_q;
    logic               phase_en_q, busy_q, done_q;
    logic [31:0]        step_q;

    // Configuration as seen on the accepting edge.
    logic               accept, in_swap, in_single, in_tri;
    logic [31:0]        in_lo, in_hi, in_first;
    logic [DWELL_W-1:0] in_dwell_m1;

    assign accept      = (state == ST_IDLE) && sw.start && !sw.abort;
    assign in_swap     = sw.cfg_start_step > sw.cfg_stop_step;
    assign in_lo       = in_swap ? sw.cfg_stop_step  : sw.cfg_start_step;
    assign in_hi       = in_swap ? sw.cfg_start_step : sw.cfg_stop_step;
    assign in_first    = (sw.cfg_incr == '0) ? sw.cfg_start_step : in_lo;
    assign in_dwell_m1 = (sw.cfg_dwell == '0) ? '0 : sw.cfg_dwell - DWELL_W'(1);
    assign in_single   = (sw.cfg_incr == '0) || (sw.cfg_mode == MODE_SINGLE) || (sw.cfg_mode == 2'b11);
    assign in_tri      = !in_single && (sw.cfg_mode == MODE_TRI);

    logic expire, tmr_load;
    assign tmr_load = accept || ((state == ST_RUN) && expire && !sw.abort);

    sweep_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .load     (tmr_load),
        .load_val (accept ? in_dwell_m1 : dwell_m1_q),
        .en       (state == ST_RUN),
        .expire   (expire)
    );

    // Next-point arithmetic; a zero increment always ends the leg after one point.
    sum33_t up_sum, dn_dif;
    logic   up_end, dn_end, fin, nxt_down;
    logic [31:0] nxt;

    assign up_sum = {1'b0, cur_q} + {1'b0, incr_q};
    assign dn_dif = {1'b0, cur_q} - {1'b0, incr_q};
    assign up_end = up_sum[32] || (up_sum[31:0] > hi_q) || (incr_q == '0);
    assign dn_end = dn_dif[32] || (dn_dif[31:0] < lo_q);

    always_comb begin
        fin      = 1'b0;
        nxt      = cur_q;
        nxt_down = down_q;
        if (!down_q) begin
            if (!up_end)       nxt = up_sum[31:0];
            else if (single_q) fin = 1'b1;
            else if (!tri_q)   nxt = lo_q;
            else if (!dn_end) begin
                nxt      = dn_dif[31:0];
                nxt_down = 1'b1;
            end
            // Triangle with a single point that fits: keep re-emitting it.
        end else if (!dn_end) begin
            nxt = dn_dif[31:0];
        end else begin
            nxt      = up_sum[31:0];
            nxt_down = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            lo_q       <= '0;
            hi_q       <= '0;
            incr_q     <= '0;
            cur_q      <= '0;
            dwell_m1_q <= '0;
            single_q   <= 1'b1;
            tri_q      <= 1'b0;
            down_q     <= 1'b0;
            phase_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            step_q     <= DEFAULT_STEP;
        end else begin
            phase_en_q <= 1'b0;
            done_q     <= 1'b0;
            case (state)
                ST_IDLE: if (accept) begin
                    lo_q       <= in_lo;
                    hi_q       <= in_hi;
                    incr_q     <= sw.cfg_incr;
                    dwell_m1_q <= in_dwell_m1;
                    single_q   <= in_single;
                    tri_q      <= in_tri;
                    down_q     <= 1'b0;
                    cur_q      <= in_first;
                    step_q     <= clamp_step(in_first);
                    phase_en_q <= 1'b1;
                    busy_q     <= 1'b1;
                    state      <= ST_RUN;
                end
                ST_RUN: if (sw.abort) begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end else if (expire) begin
                    if (fin) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end else begin
                        cur_q      <= nxt;
                        down_q     <= nxt_down;
                        step_q     <= clamp_step(nxt);
                        phase_en_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign sw.phase_en       = phase_en_q;
    assign sw.set_phase_step = step_q;
    assign sw.busy           = busy_q;
    assign sw.done           = done_q;
endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Bench for freq_sweep_ctrl: point-list reference model checked every cycle,
// directed scenarios with literal expectations, then randomized sweeps.
module tb_freq_sweep_ctrl;
    localparam int DWELL_W = 32;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cur_cyc = 0;

    freq_sweep_ctrl_if #(.DWELL_W(DWELL_W)) sw();

    freq_sweep_ctrl #(.DWELL_W(DWELL_W)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .sw       (sw)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference: the sweep is the list of points it visits; cycle c (c>=1
    // after the accepting edge) shows point (c-1)/D of that list.
    longint     seq[$];
    bit         m_act = 0, m_single = 1;
    int         m_c = 0, m_d = 1, m_n = 0;
    logic       m_pe = 0, m_busy = 0, m_done = 0;
    logic [31:0] m_step = 32'd26030;

    function automatic logic [31:0] clamp_ref(input longint v);
        longint r;
        r = (v < 26) ? 26 : (v > 1301505241) ? 1301505241 : v;
        return r[31:0];
    endfunction

    function automatic void build_seq();
        longint a, b, lo, hi, inc;
        longint up[$];
        bit     tri_m;
        a   = longint'(sw.cfg_start_step);
        b   = longint'(sw.cfg_stop_step);
        inc = longint'(sw.cfg_incr);
        lo  = (a < b) ? a : b;
        hi  = (a < b) ? b : a;
        m_d = (sw.cfg_dwell == 0) ? 1 : int'(sw.cfg_dwell);
        seq.delete();
        if (inc == 0) begin
            seq.push_back(a);
            m_single = 1;
        end else begin
            for (longint v = lo; v <= hi && up.size() < 4000; v += inc) up.push_back(v);
            m_single = !(sw.cfg_mode == 2'b01 || sw.cfg_mode == 2'b10);
            tri_m    = (sw.cfg_mode == 2'b10);
            seq = up;
            if (tri_m)
                for (int i = up.size() - 2; i >= 1; i--) seq.push_back(up[i]);
        end
        m_n = seq.size();
    endfunction

    function automatic void show_point();
        int idx;
        idx    = (m_c - 1) / m_d;
        m_busy = 1'b1;
        m_pe   = ((m_c - 1) % m_d) == 0;
        m_step = clamp_ref(seq[idx % seq.size()]);
    endfunction

    always @(posedge sys_clk) begin : model
        if (!sys_rst_n) begin
            m_act = 0; m_pe = 0; m_busy = 0; m_done = 0; m_step = 32'd26030;
        end else begin
            m_pe = 0; m_done = 0;
            if (m_act) begin
                if (sw.abort) begin
                    m_act = 0; m_busy = 0;
                end else begin
                    m_c++;
                    if (m_single && m_c == 1 + m_n * m_d) begin
                        m_act = 0; m_busy = 0; m_done = 1;
                    end else show_point();
                end
            end else if (sw.start && !sw.abort) begin
                build_seq();
                m_c = 1; m_act = 1;
                show_point();
            end
        end
    end

    always @(negedge sys_clk) begin : compare
        if (sys_rst_n) begin
            chk("phase_en", 32'(sw.phase_en), 32'(m_pe));
            chk("set_phase_step", sw.set_phase_step, m_step);
            chk("busy", 32'(sw.busy), 32'(m_busy));
            chk("done", 32'(sw.done), 32'(m_done));
        end
    end

    task automatic set_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] i,
                           input logic [31:0] d, input logic [1:0] m);
        sw.cfg_start_step = s; sw.cfg_stop_step = e; sw.cfg_incr = i;
        sw.cfg_dwell = d; sw.cfg_mode = m;
    endtask

    // Call between edges; the following edge is edge 0, then we sit in cycle 1.
    task automatic start_sweep(input logic [31:0] s, input logic [31:0] e, input logic [31:0] i,
                               input logic [31:0] d, input logic [1:0] m);
        set_cfg(s, e, i, d, m);
        sw.start = 1'b1;
        @(posedge sys_clk); #1;
        sw.start = 1'b0;
        cur_cyc = 1;
    endtask

    task automatic goto_cyc(input int k);
        repeat (k - cur_cyc) @(posedge sys_clk);
        cur_cyc = k;
        @(negedge sys_clk);
    endtask

    task automatic pulse_abort();
        sw.abort = 1'b1;
        @(posedge sys_clk); #1;
        sw.abort = 1'b0;
        repeat (2) @(posedge sys_clk); #1;
    endtask

    task automatic rand_cfg();
        logic [31:0] s, e, i, span;
        case ($urandom_range(0, 3))
            0: begin
                s = $urandom_range(0, 3000); span = $urandom_range(0, 1000);
                e = s + span; i = $urandom_range(span / 8 + 1, span + 20);
            end
            1: begin
                s = $urandom_range(1301504000, 1301506000);
                e = 32'hFFFF_FFFF - $urandom_range(0, 1000);
                i = $urandom_range(32'h3000_0000, 32'hFFFF_FFFF);
            end
            2: begin
                e = $urandom_range(0, 3000); s = e + $urandom_range(1, 1000);
                i = $urandom_range(50, 400);
            end
            default: begin
                s = $urandom_range(0, 100000); e = s; i = $urandom_range(1, 10);
            end
        endcase
        if ($urandom_range(0, 7) == 0) i = 0;
        set_cfg(s, e, i, $urandom_range(0, 4), 2'($urandom_range(0, 3)));
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] saw_w [6];
        logic [31:0] tri_w [8];
        saw_w = '{1000, 1100, 1200, 1000, 1100, 1200};
        tri_w = '{26, 100, 200, 300, 200, 100, 26, 100};
        set_cfg(0, 0, 0, 0, 0);
        sw.start = 1'b0; sw.abort = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("reset_step", sw.set_phase_step, 32'd26030);
        chk("reset_busy", 32'(sw.busy), 0);
        chk("reset_pe", 32'(sw.phase_en), 0);
        chk("reset_done", 32'(sw.done), 0);
        sys_rst_n = 1'b1;

        // Single sweep 1000..1300 step 100, dwell 4.
        start_sweep(1000, 1300, 100, 4, 2'b00);
        goto_cyc(1);  chk("t1_c1_step", sw.set_phase_step, 1000); chk("t1_c1_pe", 32'(sw.phase_en), 1);
        goto_cyc(5);  chk("t1_c5_step", sw.set_phase_step, 1100);
        goto_cyc(9);  chk("t1_c9_step", sw.set_phase_step, 1200);
        goto_cyc(13); chk("t1_c13_step", sw.set_phase_step, 1300);
        goto_cyc(16); chk("t1_c16_busy", 32'(sw.busy), 1); chk("t1_c16_done", 32'(sw.done), 0);
        goto_cyc(17); chk("t1_c17_done", 32'(sw.done), 1); chk("t1_c17_busy", 32'(sw.busy), 0);
        goto_cyc(18); chk("t1_c18_done", 32'(sw.done), 0); chk("t1_c18_step", sw.set_phase_step, 1300);

        // Sawtooth, dwell 1.
        start_sweep(1000, 1250, 100, 1, 2'b01);
        for (int k = 1; k <= 6; k++) begin
            goto_cyc(k);
            chk("t2_step", sw.set_phase_step, saw_w[k-1]);
            chk("t2_pe", 32'(sw.phase_en), 1);
        end
        pulse_abort();

        // Triangle 0..300 step 100, dwell 2.
        start_sweep(0, 300, 100, 2, 2'b10);
        for (int k = 0; k < 8; k++) begin
            goto_cyc(1 + 2 * k);
            chk("t3_step", sw.set_phase_step, tri_w[k]);
        end
        pulse_abort();

        // Clamp and carry.
        start_sweep(1301505000, 32'hFFFF_FFFF, 32'h8000_0000, 3, 2'b00);
        goto_cyc(1); chk("t4_c1_step", sw.set_phase_step, 1301505000);
        goto_cyc(4); chk("t4_c4_step", sw.set_phase_step, 1301505241);
        goto_cyc(7); chk("t4_c7_done", 32'(sw.done), 1);
        @(posedge sys_clk); #1;

        // Abort in cycle 7, restart in cycle 8 with a zero-increment swapped config.
        start_sweep(1000, 1300, 100, 4, 2'b00);
        goto_cyc(7);
        sw.abort = 1'b1;
        @(posedge sys_clk); #1;
        sw.abort = 1'b0;
        set_cfg(500, 200, 0, 3, 2'b10);
        sw.start = 1'b1;
        @(negedge sys_clk);
        chk("t5_c8_busy", 32'(sw.busy), 0);
        chk("t5_c8_step", sw.set_phase_step, 1100);
        chk("t5_c8_done", 32'(sw.done), 0);
        @(posedge sys_clk); #1;
        sw.start = 1'b0;
        cur_cyc = 1;
        goto_cyc(1); chk("t6_c1_step", sw.set_phase_step, 500);
        goto_cyc(4); chk("t6_c4_done", 32'(sw.done), 1);

        // start and abort together in IDLE: dropped.
        @(posedge sys_clk); #1;
        sw.start = 1'b1; sw.abort = 1'b1;
        @(posedge sys_clk); #1;
        sw.start = 1'b0; sw.abort = 1'b0;
        @(negedge sys_clk);
        chk("start_abort_busy", 32'(sw.busy), 0);

        // Reset mid-sweep.
        start_sweep(1000, 1250, 100, 1, 2'b01);
        goto_cyc(3);
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_step", sw.set_phase_step, 32'd26030);
        chk("midrst_busy", 32'(sw.busy), 0);
        chk("midrst_pe", 32'(sw.phase_en), 0);
        chk("midrst_done", 32'(sw.done), 0);
        @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;

        // Randomized sweeps; config churns while running to exercise latching.
        for (int t = 0; t < 30; t++) begin
            rand_cfg();
            sw.start = 1'b1;
            @(posedge sys_clk); #1;
            sw.start = 1'b0;
            for (int k = 0, n = $urandom_range(10, 80); k < n; k++) begin
                rand_cfg();
                sw.abort = ($urandom_range(0, 39) == 0);
                sw.start = ($urandom_range(0, 7) == 0);
                @(posedge sys_clk); #1;
            end
            sw.start = 1'b0;
            pulse_abort();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
